// File: rtl/add32_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package add32_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic {IDLE, BUSY} state_t;

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/add32_cla.sv
// 32-bit adder built from 4-bit carry-lookahead groups; sits outside the sequencer.
module add32_cla (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic [32:0] c;
        c    = '0;
        c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = w_g[4*k] | (w_p[4*k] & c[4*k]);
            c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
            c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c[4*k]);
        end
        o_sum  = w_p ^ c[31:0];
        o_cout = c[32];
    end

endmodule

// File: rtl/add32_mp_seq.sv
// Multi-precision add/subtract sequencer driving an external 32-bit adder word by word.
// Optional signed-overflow output out_ovf is enabled by defining ADD32_SIGNED_OVF_EN.
module add32_mp_seq
    import add32_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic [WORD_W-1:0] add_a,
    output logic [WORD_W-1:0] add_b,
    output logic              add_cin,
    input  logic [WORD_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_err
`ifdef ADD32_SIGNED_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int unsigned CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;
    logic               r_sub;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_sum;
    logic               r_out_last;
    logic               r_out_carry;
    logic               r_out_err;

    logic               w_start;
    logic               w_eff_sub;
    logic [CNT_W-1:0]   w_cnt_eff;
    logic               w_at_max;
    logic               w_last_eff;
    logic               w_err;
    logic               w_accept;
    logic               w_pop;

    // A first word (explicit or implied by IDLE) always counts from zero.
    assign w_start    = in_first | (r_state == IDLE);
    assign w_eff_sub  = w_start ? in_sub : r_sub;
    assign w_cnt_eff  = w_start ? '0 : r_count;
    assign w_at_max   = (w_cnt_eff == CNT_W'(MAX_WORDS - 1));
    assign w_last_eff = in_last | w_at_max;
    assign w_err      = (in_first & (r_state == BUSY)) | (w_at_max & ~in_last);

    assign add_a   = in_a;
    assign add_b   = w_eff_sub ? ~in_b : in_b;
    assign add_cin = w_start ? in_sub : r_carry;

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_carry <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= add_sum;
            r_out_last  <= w_last_eff;
            r_out_carry <= w_last_eff & add_cout;
            r_out_err   <= w_err;
            r_carry     <= add_cout;
            if (w_start) begin
                r_sub <= in_sub;
            end
            if (w_last_eff) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                r_state <= BUSY;
                r_count <= w_cnt_eff + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_carry = r_out_carry;
    assign out_err   = r_out_err;

`ifdef ADD32_SIGNED_OVF_EN
    logic r_out_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_ovf <= 1'b0;
        end else if (w_accept) begin
            r_out_ovf <= w_last_eff & signed_ovf(in_a[WORD_W-1], add_b[WORD_W-1],
                                                 add_sum[WORD_W-1]);
        end
    end

    assign out_ovf = r_out_ovf;
`endif

endmodule

// File: doc/add32_mp_seq.md
Name: add32_mp_seq

Overview:
Multi-precision add/subtract sequencer wrapped around the 32-bit carry-lookahead adder. It accepts operands one 32-bit word per beat, least-significant word first. It drives the adder's operand and carry-in inputs and chains the adder's carry-out into the next word's carry-in. Each registered word result goes out on a valid/ready stream, so the block sits both upstream of the adder (feeding it) and downstream (consuming sum/carry).

Parameters:
MAX_WORDS, 4, maximum words per operation (2..16); word counter width is clog2(MAX_WORDS).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_a  in  32  operand A word
in_b  in  32  operand B word
in_first  in  1  first (least-significant) word of an operation
in_last  in  1  last (most-significant) word of an operation
in_sub  in  1  1 = A-B, 0 = A+B; sampled on first word only
add_a  out  32  to adder operand A (combinational)
add_b  out  32  to adder operand B (combinational)
add_cin  out  1  to adder carry-in (combinational)
add_sum  in  32  from adder result
add_cout  in  1  from adder carry-out
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts result word
out_sum  out  32  result word
out_last  out  1  result word is most-significant
out_carry  out  1  final carry-out (sub: 1 = no borrow); valid only with out_last
out_err  out  1  framing error attached to this result word

Behaviour:
- Reset (async): out_valid=0, out_sum=0, out_last=0, out_carry=0, out_err=0, carry_q=0, sub_q=0, word count=0, state=IDLE.
- in_ready = !out_valid | out_ready. This is a single output register with pass-through on simultaneous pop/push. There is no combinational path from in_valid to in_ready.
- Adder drive is always combinational from the inputs, regardless of in_valid:
  - eff_sub = start ? in_sub : sub_q.
  - add_a = in_a.
  - add_b = eff_sub ? ~in_b : in_b.
  - add_cin = start ? in_sub : carry_q.
  - start = in_first | (state==IDLE).
- Accept (in_valid & in_ready), registered next edge, latency 1:
  - out_sum <= add_sum.
  - out_valid <= 1.
  - carry_q <= add_cout.
  - out_last <= last_eff.
  - out_carry <= add_cout if last_eff, else 0.
  - last_eff = in_last | (count==MAX_WORDS-1).
- Pop without push: out_valid <= 0; other output fields hold.
- FSM IDLE/BUSY:
  - IDLE, accept with !last_eff -> BUSY; sub_q <= in_sub; count <= 1.
  - IDLE, accept with last_eff -> stays IDLE (single-word op).
  - BUSY, accept -> count+1; last_eff -> IDLE with count <= 0.
- Error cases (out_err=1 on the affected result word; processing continues):
  - in_first while BUSY: previous op abandoned with no out_last emitted; word restarts as first.
  - count reaches MAX_WORDS-1 without in_last: word is forced last.
  - A word in IDLE without in_first is treated as first; no error.
- Stall: while out_valid & !out_ready, all state and out_* hold. Adder outputs are ignored because no accept occurs.
- rst mid-operation: state, count and carry are discarded immediately; any partial op is dropped.

Optional Feature:
ADD32_SIGNED_OVF_EN.
- Defined: adds output port out_ovf (1 bit). On the last word it registers signed overflow: (in_a[31] ~^ add_b[31]) & (add_sum[31] ^ in_a[31]). It is 0 on non-last words and resets to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package add32_pkg holds:
  - WORD_W=32.
  - enum state_t {IDLE, BUSY}.
  - A helper function for the signed overflow expression.
- The adder stays outside the block, connected at the top level via the add_* ports. The testbench instantiates the real adder.
- No further sub-module. Output register and FSM live in one module.

Test Plan:
- Single-word add: A=0xFFFF_FFFF, B=0x1, first=last=1, sub=0 -> one beat: out_sum=0x0, out_carry=1, out_last=1, out_err=0.
- 64-bit add: words (0xFFFF_FFFF,0x1) then (0x0,0x0), sub=0 -> out_sum 0x0 then 0x1; out_carry=0; out_last only on the second beat.
- 64-bit subtract: A=0x1_0000_0000, B=0x1, sub=1 -> words 0xFFFF_FFFF, 0x0; out_carry=1 (no borrow). Swap operands -> 0x1, 0xFFFF_FFFF, out_carry=0.
- Backpressure: out_ready=0 for 3 cycles with continuous in_valid -> in_ready=0, out_sum holds. Then release -> one beat per cycle with the carry chain intact.
- Framing: in_first while BUSY -> new word flagged out_err=1 with a fresh carry-in. MAX_WORDS=4 with 5 words and no in_last -> the 4th beat has out_last=1, out_err=1.
- Async reset asserted mid-operation between words -> out_valid=0 the same cycle. The next word computes with carry-in 0 as a first word.
